// File: rtl/bt_cmd_ctrl.sv
// rtl/bt_cmd_ctrl.sv - Bluetooth byte-command decoder driving playback volume, song, pause, mute and mode
module bt_cmd_ctrl #(
    parameter int         SONG_NUM    = 2,
    parameter int         SEL_W       = 5,
    parameter int         VOL_STEP    = 14,
    parameter logic [7:0] ATT_MAX     = 8'hFC,
    parameter int         ARG_TIMEOUT = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_rx_valid,
    input  logic [7:0]       i_rx_data,
    input  logic             i_FINISH,
    output logic [15:0]      o_vol,
    output logic [SEL_W-1:0] o_song_select,
    output logic             o_pause,
    output logic             o_mute,
    output logic [1:0]       o_mode,
    output logic             o_song_change,
    output logic             o_cmd_err
);

    typedef enum logic {IDLE, WAIT_ARG} state_t;

    localparam logic [7:0]       SONG_B   = 8'(SONG_NUM);
    localparam logic [15:0]      SONG_W16 = 16'(SONG_NUM);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(SONG_NUM - 1);
    localparam logic [7:0]       STEP_B   = 8'(VOL_STEP);
    localparam logic [7:0]       DN_LIM   = ATT_MAX - STEP_B;
    localparam logic [31:0]      TMO_LAST = 32'(ARG_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic             op_att_q, op_att_d;     // latched two-byte opcode: 1 = set attenuation, 0 = select song
    logic [31:0]      timer_q, timer_d;
    logic [7:0]       att_q, att_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             pause_q, pause_d;
    logic             mute_q, mute_d;
    logic [1:0]       mode_q, mode_d;
    logic             chg_q, chg_d;
    logic             err_q, err_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic             pend_q, pend_d;
    logic             fin_q;

    logic             fin_rise;
    logic [15:0]      rem;
    logic [SEL_W-1:0] cand;
    logic [SEL_W-1:0] shuf_sel;
    logic [7:0]       k;

    function automatic logic [SEL_W-1:0] sel_next(input logic [SEL_W-1:0] s);
        return (s == LAST_SEL) ? '0 : s + 1'b1;
    endfunction

    function automatic logic [SEL_W-1:0] sel_prev(input logic [SEL_W-1:0] s);
        return (s == '0) ? LAST_SEL : s - 1'b1;
    endfunction

    assign fin_rise = i_FINISH & ~fin_q;
    assign k        = {2'b00, i_rx_data[5:0]};

    // Shuffle candidate: LFSR modulo song count, bumped by one if it would replay the current song
    always_comb begin
        rem      = lfsr_q % SONG_W16;
        cand     = rem[SEL_W-1:0];
        shuf_sel = '0;
        if (SONG_NUM > 1) begin
            shuf_sel = (cand == sel_q) ? sel_next(cand) : cand;
        end
    end

    // Next-state and command decode; received bytes always win over pending end-of-song service
    always_comb begin
        state_d  = state_q;
        op_att_d = op_att_q;
        timer_d  = timer_q;
        att_d    = att_q;
        sel_d    = sel_q;
        pause_d  = pause_q;
        mute_d   = mute_q;
        mode_d   = mode_q;
        chg_d    = 1'b0;
        err_d    = 1'b0;
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        pend_d   = pend_q | fin_rise;

        case (state_q)
            IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        8'h01: pause_d = ~pause_q;
                        8'h02: begin sel_d = sel_next(sel_q); pause_d = 1'b0; chg_d = 1'b1; end
                        8'h03: begin sel_d = sel_prev(sel_q); pause_d = 1'b0; chg_d = 1'b1; end
                        8'h04: att_d = (att_q < STEP_B) ? 8'h00 : att_q - STEP_B;
                        8'h05: att_d = (att_q > DN_LIM) ? ATT_MAX : att_q + STEP_B;
                        8'h06: mute_d = ~mute_q;
                        8'h07: mode_d = (mode_q == 2'd2) ? 2'd0 : mode_q + 2'd1;
                        8'h10, 8'h11: begin
                            op_att_d = i_rx_data[0];
                            timer_d  = '0;
                            state_d  = WAIT_ARG;
                        end
                        default: begin
                            if (i_rx_data[7:6] == 2'b01 && k < SONG_B) begin
                                sel_d   = SEL_W'(k);
                                pause_d = 1'b0;
                                chg_d   = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                    endcase
                end else if (pend_q) begin
                    // A fresh edge arriving during service starts a new pending request
                    pend_d = fin_rise;
                    chg_d  = 1'b1;
                    case (mode_q)
                        2'd1:    sel_d = sel_q;
                        2'd2:    sel_d = shuf_sel;
                        default: sel_d = sel_next(sel_q);
                    endcase
                end
            end
            WAIT_ARG: begin
                if (i_rx_valid) begin
                    state_d = IDLE;
                    if (op_att_q) begin
                        att_d = (i_rx_data > ATT_MAX) ? ATT_MAX : i_rx_data;
                    end else if (i_rx_data < SONG_B) begin
                        sel_d   = SEL_W'(i_rx_data);
                        pause_d = 1'b0;
                        chg_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (timer_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_att_q <= 1'b0;
            timer_q  <= '0;
            att_q    <= 8'h00;
            sel_q    <= '0;
            pause_q  <= 1'b0;
            mute_q   <= 1'b0;
            mode_q   <= 2'd0;
            chg_q    <= 1'b0;
            err_q    <= 1'b0;
            lfsr_q   <= 16'hACE1;
            pend_q   <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_att_q <= op_att_d;
            timer_q  <= timer_d;
            att_q    <= att_d;
            sel_q    <= sel_d;
            pause_q  <= pause_d;
            mute_q   <= mute_d;
            mode_q   <= mode_d;
            chg_q    <= chg_d;
            err_q    <= err_d;
            lfsr_q   <= lfsr_d;
            pend_q   <= pend_d;
            fin_q    <= i_FINISH;
        end
    end

    assign o_vol         = mute_q ? {ATT_MAX, ATT_MAX} : {att_q, att_q};
    assign o_song_select = sel_q;
    assign o_pause       = pause_q;
    assign o_mute        = mute_q;
    assign o_mode        = mode_q;
    assign o_song_change = chg_q;
    assign o_cmd_err     = err_q;

endmodule

// File: tb/tb_bt_cmd_ctrl.sv
// tb/tb_bt_cmd_ctrl.sv - directed self-checking bench for bt_cmd_ctrl
module tb_bt_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        finish = 1'b0;

    logic [15:0] vol4, vol3;
    logic [4:0]  sel4, sel3;
    logic        pause4, pause3, mute4, mute3, chg4, chg3, err4, err3;
    logic [1:0]  mode4, mode3;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    bt_cmd_ctrl #(.SONG_NUM(4), .SEL_W(5), .VOL_STEP(14), .ATT_MAX(8'hFC), .ARG_TIMEOUT(100)) dut4 (
        .clk(clk), .rst_n(rst_n), .i_rx_valid(rx_valid), .i_rx_data(rx_data), .i_FINISH(finish),
        .o_vol(vol4), .o_song_select(sel4), .o_pause(pause4), .o_mute(mute4), .o_mode(mode4),
        .o_song_change(chg4), .o_cmd_err(err4)
    );

    bt_cmd_ctrl #(.SONG_NUM(3), .SEL_W(5), .VOL_STEP(14), .ATT_MAX(8'hFC), .ARG_TIMEOUT(100)) dut3 (
        .clk(clk), .rst_n(rst_n), .i_rx_valid(rx_valid), .i_rx_data(rx_data), .i_FINISH(finish),
        .o_vol(vol3), .o_song_select(sel3), .o_pause(pause3), .o_mute(mute3), .o_mode(mode3),
        .o_song_change(chg3), .o_cmd_err(err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    logic [4:0] prev;
    logic [3:0] visited;
    int         bad_range, bad_repeat, bad_pulse;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_vol", vol4, 16'h0000);
        chk("rst_sel", sel4, 0);
        chk("rst_pause", pause4, 0);
        chk("rst_mute", mute4, 0);
        chk("rst_mode", mode4, 0);
        chk("rst_chg", chg4, 0);
        chk("rst_err", err4, 0);
        rst_n = 1'b1;

        // volume saturation both ways
        send(8'h05); send(8'h05); send(8'h05);
        chk("vol_dn3", vol4, 16'h2A2A);
        send(8'h04); send(8'h04); send(8'h04);
        chk("vol_up3", vol4, 16'h0000);
        send(8'h04);
        chk("vol_up_sat", vol4, 16'h0000);

        // set attenuation clamps to ATT_MAX; mute and volume while muted
        send(8'h11); send(8'hFF);
        chk("set_att_clamp", vol4, 16'hFCFC);
        send(8'h06);
        chk("mute_on", mute4, 1);
        chk("mute_vol", vol4, 16'hFCFC);
        send(8'h04);
        chk("muted_volup", vol4, 16'hFCFC);
        chk("muted_still", mute4, 1);
        send(8'h06);
        chk("unmute_vol", vol4, 16'hEEEE);
        send(8'h11); send(8'h30);
        chk("set_att_30", vol4, 16'h3030);

        // song wrap with SONG_NUM = 3
        send(8'h42);
        chk("direct_sel3", sel3, 2);
        chk("direct_chg3", chg3, 1);
        send(8'h02);
        chk("next_wrap3", sel3, 0);
        chk("next_chg3", chg3, 1);
        @(negedge clk);
        chk("chg_one_cycle", chg3, 0);
        send(8'h03);
        chk("prev_wrap3", sel3, 2);
        send(8'h43);
        chk("bad_k_err3", err3, 1);
        chk("bad_k_sel3", sel3, 2);
        chk("bad_k_chg3", chg3, 0);
        @(negedge clk);
        chk("err_one_cycle", err3, 0);
        chk("dut4_sel_43", sel4, 3);

        // unknown opcode and out-of-range argument
        send(8'h20);
        chk("unknown_err", err4, 1);
        send(8'h10); send(8'h04);
        chk("arg_range_err", err4, 1);
        chk("arg_range_sel", sel4, 3);
        send(8'h10); send(8'h01);
        chk("arg_sel", sel4, 1);
        chk("arg_chg", chg4, 1);

        // argument timeout
        send(8'h10);
        repeat (99) @(negedge clk);
        chk("tmo_not_yet", err4, 0);
        @(negedge clk);
        chk("tmo_err", err4, 1);
        send(8'h01);
        chk("after_tmo_pause", pause4, 1);
        send(8'h02);
        chk("sel_clears_pause", pause4, 0);
        chk("next_sel4", sel4, 2);

        // repeat-one: byte has priority over the simultaneous finish edge
        send(8'h07);
        chk("mode_rep1", mode4, 1);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'h02; finish = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("rep1_next_sel", sel4, 3);
        chk("rep1_next_chg", chg4, 1);
        @(negedge clk);
        chk("rep1_fin_chg", chg4, 1);
        chk("rep1_fin_sel", sel4, 3);
        finish = 1'b0;
        @(negedge clk);
        chk("rep1_chg_done", chg4, 0);

        // sequential: finish held off during WAIT_ARG
        send(8'h07); send(8'h07);
        chk("mode_seq", mode4, 0);
        send(8'h10);
        finish = 1'b1;
        repeat (2) @(negedge clk);
        finish = 1'b0;
        chk("wait_no_fin_sel", sel4, 3);
        chk("wait_no_fin_chg", chg4, 0);
        send(8'h01);
        chk("wait_arg_sel", sel4, 1);
        @(negedge clk);
        chk("seq_fin_sel", sel4, 2);
        chk("seq_fin_chg", chg4, 1);

        // shuffle
        send(8'h07); send(8'h07);
        chk("mode_shuf", mode4, 2);
        visited = 4'b0000;
        bad_range = 0; bad_repeat = 0; bad_pulse = 0;
        for (int i = 0; i < 200; i++) begin
            prev = sel4;
            @(negedge clk);
            finish = 1'b1;
            @(negedge clk);
            finish = 1'b0;
            @(negedge clk);
            if (chg4 !== 1'b1) bad_pulse++;
            if (sel4 > 5'd3) bad_range++;
            else visited[sel4[1:0]] = 1'b1;
            if (sel4 === prev) bad_repeat++;
            @(negedge clk);
        end
        chk("shuf_range", bad_range, 0);
        chk("shuf_repeat", bad_repeat, 0);
        chk("shuf_pulse", bad_pulse, 0);
        chk("shuf_visited", visited, 4'hF);

        // reset mid-command drops the pending opcode
        send(8'h11);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_mode", mode4, 0);
        rst_n = 1'b1;
        send(8'h01);
        chk("rst_mid_pause", pause4, 1);
        chk("rst_mid_vol", vol4, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bt_cmd_ctrl.md
Name: bt_cmd_ctrl

Overview:
Parametrised successor to the single-byte Bluetooth command decoder in the MP3 player. It consumes bytes from the UART receiver and drives the volume, song-select, pause, mute and play-mode state of the playback path. Additions over the previous generation:
- two-byte commands (opcode + argument) with an argument timeout;
- mute;
- play modes: sequential, repeat-one, shuffle;
- automatic advance on end-of-song;
- saturating, parameter-bounded volume arithmetic;
- error and song-change strobes.

Parameters:
- SONG_NUM, 2: number of songs; legal indices 0..SONG_NUM-1 (1..32).
- SEL_W, 5: width of o_song_select.
- VOL_STEP, 14: attenuation change per volume command.
- ATT_MAX, 8'hFC: maximum per-channel attenuation; 0 is loudest.
- ARG_TIMEOUT, 50_000_000: cycles to wait for an argument byte before abandoning the command.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_rx_valid  in  1  one-cycle strobe: i_rx_data holds a received byte.
- i_rx_data  in  8  received byte.
- i_FINISH  in  1  level from the decoder, high when the current song has ended.
- o_vol  out  16  {left_att, right_att}.
- o_song_select  out  SEL_W  current song index.
- o_pause  out  1  1 = paused.
- o_mute  out  1  1 = muted.
- o_mode  out  2  play mode: 0 = SEQ, 1 = REPEAT_ONE, 2 = SHUFFLE.
- o_song_change  out  1  one-cycle pulse each time a song (re)start is commanded.
- o_cmd_err  out  1  one-cycle pulse on an unknown opcode, out-of-range argument, or argument timeout.

Behaviour:
Clock and reset
- Single clock domain; reset is asynchronous, active-low, on rst_n.
- Reset values: o_vol = 0, o_song_select = 0, o_pause = 0, o_mute = 0, o_mode = 0, both pulses = 0, FSM = IDLE, internal attenuation = 0, LFSR = 16'hACE1, finish_pend = 0.
- Reset mid-command discards any partial opcode.

Latency
- A byte sampled at edge N with i_rx_valid = 1 updates outputs at edge N.
- Outputs are visible in the following cycle; pulses are high for exactly that one cycle.

FSM
- States: IDLE, WAIT_ARG.
- IDLE, single-byte opcodes, executed immediately:
  - 0x01: toggle pause.
  - 0x02: next.
  - 0x03: previous.
  - 0x04: volume up, att = (att < VOL_STEP) ? 0 : att - VOL_STEP, both channels.
  - 0x05: volume down, att = (att > ATT_MAX - VOL_STEP) ? ATT_MAX : att + VOL_STEP.
  - 0x06: toggle mute.
  - 0x07: cycle mode SEQ -> REPEAT_ONE -> SHUFFLE -> SEQ.
  - 0x40 + k: select song k if k < SONG_NUM, else o_cmd_err.
- IDLE, two-byte opcodes:
  - 0x10 (select song) or 0x11 (set attenuation): latch the opcode, clear the timer, go to WAIT_ARG.
- IDLE, any other byte: o_cmd_err pulse; state unchanged.
- WAIT_ARG, on the next valid byte, then return to IDLE:
  - 0x10: select the argument if < SONG_NUM, else o_cmd_err.
  - 0x11: both channels' att = min(arg, ATT_MAX).
- WAIT_ARG timeout: after ARG_TIMEOUT cycles with no byte, raise o_cmd_err and return to IDLE.
- All received bytes are consumed; none are dropped.

Song selection
- Next: index + 1, wrapping SONG_NUM-1 -> 0.
- Previous: index - 1, wrapping 0 -> SONG_NUM-1.
- Any commanded selection (next, previous, direct, argument) sets o_pause = 0 and pulses o_song_change, including reselection of the same index.

Volume and mute
- o_vol = {ATT_MAX, ATT_MAX} while o_mute = 1; otherwise {att, att}.
- Volume commands while muted update the stored att only; mute is unchanged.

End-of-song handling
- A rising edge of i_FINISH sets finish_pend; further edges while pending are absorbed.
- finish_pend is served in IDLE in a cycle with no i_rx_valid; a byte always has priority.
- Service by mode:
  - SEQ: next.
  - REPEAT_ONE: index unchanged, o_song_change pulse.
  - SHUFFLE: cand = LFSR % SONG_NUM; if cand equals the current index, use (cand + 1) wrapped. If SONG_NUM = 1, select 0.
- finish_pend is not served in WAIT_ARG and is held until IDLE.
- Finish service does not alter o_pause.

LFSR
- 16-bit Fibonacci, taps 16, 14, 13, 11.
- Free-runs every cycle.

Test Plan:
- Reset, then bytes 0x05 x3 -> o_vol = 16'h2A2A; 0x04 x4 -> o_vol = 16'h0000, saturated.
- Bytes 0x11, 0xFF -> o_vol = 16'hFCFC; 0x06 -> o_mute = 1, o_vol = FCFC; 0x04 -> o_vol still FCFC; 0x06 -> o_vol = 16'hEEEE.
- SONG_NUM = 3, index 2, byte 0x02 -> index 0 with o_song_change pulse; 0x03 -> index 2; 0x43 -> o_cmd_err pulse, index unchanged.
- Byte 0x10, then idle ARG_TIMEOUT (bench override 100) cycles -> o_cmd_err pulse at cycle 100; next byte 0x01 decoded as pause (o_pause = 1).
- Mode REPEAT_ONE, i_FINISH rises in the same cycle as byte 0x02 -> next executes first, then the finish service pulses o_song_change again with the index unchanged.
- Mode SHUFFLE, 200 i_FINISH edges with SONG_NUM = 4 -> every index stays in 0..3, never repeats consecutively, and all four indices are visited.
